clkdiv_prog: RTL and testbench

Programmable clock-enable divider; the parametrised successor of the fixed 2-bit divider in the VGA controller. It divides `clk` by a run-time-loadable ratio R and produces a near-50 % `clkdiv` waveform, a one-cycle `tick` enable, and the phase count. The pixel, line and frame logic uses it to derive pixel-rate enables from the board clock without a second clock domain.

---
 rtl/clkdiv_prog.sv | 111 +++++++++++
 tb/tb_clkdiv_prog.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/clkdiv_prog.sv
// Programmable clock-enable divider: divides clk by a run-time ratio R, giving clkdiv, tick, phase and load ack.
// Define CLKDIV_SHADOW_EN for glitch-free loads applied at the period wrap; default build applies loads immediately.
module clkdiv_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div,
    input  logic             div_load,
    output logic             clkdiv,
    output logic             tick,
    output logic [WIDTH-1:0] cnt,
    output logic             div_ack
);

    localparam logic [WIDTH-1:0] DEF_R = (DEFAULT_DIV < 2) ? WIDTH'(2) : WIDTH'(DEFAULT_DIV);

    function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] v);
        return (v[WIDTH-1:1] == '0) ? WIDTH'(2) : v;
    endfunction

    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             clkdiv_q, clkdiv_d;
    logic             tick_q, tick_d;
    logic             ack_q, ack_d;
    logic [WIDTH-1:0] half;
    logic [WIDTH-1:0] cnt_inc;
    logic             wrap;
`ifdef CLKDIV_SHADOW_EN
    logic [WIDTH-1:0] p_q, p_d;
    logic             pend_q, pend_d;
`endif

    // High phase length is ceil(R/2), so odd ratios carry the extra cycle high.
    assign half    = r_q - (r_q >> 1);
    assign cnt_inc = cnt_q + 1'b1;
    assign wrap    = en && (cnt_q == (r_q - 1'b1));

    always_comb begin
        r_d      = r_q;
        cnt_d    = cnt_q;
        clkdiv_d = clkdiv_q;
        tick_d   = 1'b0;
        ack_d    = 1'b0;
`ifdef CLKDIV_SHADOW_EN
        p_d      = p_q;
        pend_d   = pend_q;
`endif
        if (wrap) begin
            cnt_d    = '0;
            tick_d   = 1'b1;
            clkdiv_d = 1'b1;
        end else if (en) begin
            cnt_d    = cnt_inc;
            clkdiv_d = (cnt_inc < half);
        end
`ifdef CLKDIV_SHADOW_EN
        if (div_load) begin
            p_d    = clamp_div(div);
            pend_d = 1'b1;
        end
        // A load arriving on the wrap edge itself is applied directly at that wrap.
        if (wrap && (div_load || pend_q)) begin
            r_d    = div_load ? clamp_div(div) : p_q;
            pend_d = 1'b0;
            ack_d  = 1'b1;
        end
`else
        if (div_load) begin
            r_d      = clamp_div(div);
            cnt_d    = '0;
            clkdiv_d = 1'b1;
            tick_d   = 1'b0;
            ack_d    = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q      <= DEF_R;
            cnt_q    <= '0;
            clkdiv_q <= 1'b1;
            tick_q   <= 1'b0;
            ack_q    <= 1'b0;
`ifdef CLKDIV_SHADOW_EN
            p_q      <= DEF_R;
            pend_q   <= 1'b0;
`endif
        end else begin
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            clkdiv_q <= clkdiv_d;
            tick_q   <= tick_d;
            ack_q    <= ack_d;
`ifdef CLKDIV_SHADOW_EN
            p_q      <= p_d;
            pend_q   <= pend_d;
`endif
        end
    end

    assign clkdiv  = clkdiv_q;
    assign tick    = tick_q;
    assign cnt     = cnt_q;
    assign div_ack = ack_q;

endmodule

// File: tb/tb_clkdiv_prog.sv
// Directed bench for clkdiv_prog (WIDTH=8, DEFAULT_DIV=4); follows CLKDIV_SHADOW_EN the same way the RTL does.
module tb_clkdiv_prog;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] div;
    logic       div_load;
    logic       clkdiv;
    logic       tick;
    logic [7:0] cnt;
    logic       div_ack;

    int total = 0;
    int bad   = 0;
    int per;

    clkdiv_prog #(.WIDTH(8), .DEFAULT_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div      (div),
        .div_load (div_load),
        .clkdiv   (clkdiv),
        .tick     (tick),
        .cnt      (cnt),
        .div_ack  (div_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int c, input int cd, input int t, input int a);
        chk({tag, ".cnt"}, int'(cnt), c);
        chk({tag, ".clkdiv"}, int'(clkdiv), cd);
        chk({tag, ".tick"}, int'(tick), t);
        chk({tag, ".ack"}, int'(div_ack), a);
    endtask

    // Free run from cnt=0 with ratio r for n edges; hand rule: high while phase < ceil(r/2).
    task automatic run_chk(input string tag, input int r, input int n);
        for (int k = 1; k <= n; k++) begin
            step();
            chk_out($sformatf("%s[%0d]", tag, k), k % r, ((k % r) < (r - r / 2)) ? 1 : 0,
                    ((k % r) == 0) ? 1 : 0, 0);
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; div = 8'd0; div_load = 1'b0;
        #12;
        chk_out("reset", 0, 1, 0, 0);

        // Default ratio 4: cnt 1,2,3,0 / clkdiv 1,0,0,1 / tick on every 4th edge
        @(negedge clk);
        rst = 1'b1; en = 1'b1;
        step(); chk_out("r4.e1", 1, 1, 0, 0);
        step(); chk_out("r4.e2", 2, 0, 0, 0);
        step(); chk_out("r4.e3", 3, 0, 0, 0);
        step(); chk_out("r4.e4", 0, 1, 1, 0);
        run_chk("r4run", 4, 4);

        // Load 5 while cnt=1
        step(); chk_out("pre5", 1, 1, 0, 0);
        div = 8'd5; div_load = 1'b1;
        step();
        div_load = 1'b0;
`ifdef CLKDIV_SHADOW_EN
        chk_out("ld5.e1", 2, 0, 0, 0);
        step(); chk_out("ld5.e2", 3, 0, 0, 0);
        step(); chk_out("ld5.wrap", 0, 1, 1, 1);
`else
        chk_out("ld5.imm", 0, 1, 0, 1);
`endif
        step(); chk_out("r5.e1", 1, 1, 0, 0);
        step(); chk_out("r5.e2", 2, 1, 0, 0);
        step(); chk_out("r5.e3", 3, 0, 0, 0);
        step(); chk_out("r5.e4", 4, 0, 0, 0);
        step(); chk_out("r5.e5", 0, 1, 1, 0);

        // Loads of 0 then 1 both clamp to 2
        div = 8'd0; div_load = 1'b1;
        step();
        div = 8'd1;
`ifdef CLKDIV_SHADOW_EN
        chk_out("ld0", 1, 1, 0, 0);
        step();
        div_load = 1'b0;
        chk_out("ld1", 2, 1, 0, 0);
        step(); chk_out("ld01.e3", 3, 0, 0, 0);
        step(); chk_out("ld01.e4", 4, 0, 0, 0);
        step(); chk_out("ld01.wrap", 0, 1, 1, 1);
`else
        chk_out("ld0", 0, 1, 0, 1);
        step();
        div_load = 1'b0;
        chk_out("ld1", 0, 1, 0, 1);
`endif
        step(); chk_out("r2.e1", 1, 0, 0, 0);
        step(); chk_out("r2.e2", 0, 1, 1, 0);
        run_chk("r2run", 2, 4);

        // Back to ratio 4
        div = 8'd4; div_load = 1'b1;
        step();
        div_load = 1'b0;
`ifdef CLKDIV_SHADOW_EN
        chk_out("ld4", 1, 0, 0, 0);
        step(); chk_out("ld4.wrap", 0, 1, 1, 1);
`else
        chk_out("ld4", 0, 1, 0, 1);
`endif

        // en low for 3 cycles at cnt=2 stretches the period from 4 to 7
        step(); chk_out("gap.e1", 1, 1, 0, 0);
        step(); chk_out("gap.e2", 2, 0, 0, 0);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(); chk_out($sformatf("gap.hold%0d", k), 2, 0, 0, 0);
        end
        en = 1'b1;
        per = 5;
        for (int k = 0; k < 10; k++) begin
            step();
            per++;
            if (tick) break;
        end
        chk("gap.tick", int'(tick), 1);
        chk("gap.period", per, 7);
        chk("gap.cnt", int'(cnt), 0);

        // Asynchronous reset mid-period, with a load of 6 in flight
        div = 8'd6; div_load = 1'b1;
        step();
        div_load = 1'b0;
`ifdef CLKDIV_SHADOW_EN
        chk("rs.pend.cnt", int'(cnt), 1);
        step(); step();
        chk_out("rs.pre", 3, 0, 0, 0);
`else
        chk("rs.ld.ack", int'(div_ack), 1);
        step(); step();
        chk_out("rs.pre", 2, 1, 0, 0);
`endif
        #3;
        rst = 1'b0;
        #1;
        chk_out("rs.async", 0, 1, 0, 0);
        @(posedge clk);
        @(negedge clk);
        chk_out("rs.held", 0, 1, 0, 0);
        rst = 1'b1;
        run_chk("rs.r4", 4, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
